// File: rtl/coin_pkg.sv
// Shared types and helpers for the coin collector.
// Holds the scan FSM state type, default hitbox sizes and the saturating BCD increment.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } collect_state_t;

  localparam int COIN_W_DEFAULT   = 16;
  localparam int COIN_H_DEFAULT   = 28;
  localparam int PLAYER_W_DEFAULT = 16;
  localparam int PLAYER_H_DEFAULT = 32;

  // Widest score the helper handles; callers zero-extend narrower scores into it.
  localparam int BCD_MAX_DIGITS = 8;
  localparam int BCD_MAX_W      = 4 * BCD_MAX_DIGITS;

  // Adds one to the low 'digits' BCD digits of value, rippling the carry in one pass.
  // When every active digit is already 9 the value is returned unchanged (saturation).
  function automatic logic [BCD_MAX_W-1:0] bcd_inc_sat(input logic [BCD_MAX_W-1:0] value,
                                                       input int digits);
    logic [BCD_MAX_W-1:0] res;
    logic                 carry;
    logic                 all_nines;
    res       = value;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits && value[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
    if (!all_nines) begin
      for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
        if (i < digits && carry) begin
          if (res[4*i +: 4] == 4'd9) begin
            res[4*i +: 4] = 4'd0;
          end else begin
            res[4*i +: 4] = res[4*i +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/coin_score_bcd.sv
// Saturating BCD score counter (SCORE_DIGITS digits, at most 8).
// clr_i zeroes the score; inc_i adds one unless the score is already all 9s.
module coin_score_bcd
  import coin_pkg::*;
#(
  parameter int SCORE_DIGITS = 4
) (
  input  logic                      Clk,
  input  logic                      clr_i,
  input  logic                      inc_i,
  output logic [4*SCORE_DIGITS-1:0] score_o
);

  logic [4*SCORE_DIGITS-1:0] score_q, score_d;
  logic [BCD_MAX_W-1:0]      inc_full;

  // Next score: incremented value when inc_i, else hold.
  always_comb begin
    inc_full = bcd_inc_sat(BCD_MAX_W'(score_q), SCORE_DIGITS);
    score_d  = score_q;
    if (inc_i) score_d = inc_full[4*SCORE_DIGITS-1:0];
  end

  // Score register with synchronous clear.
  always_ff @(posedge Clk) begin
    if (clr_i) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score_o = score_q;

endmodule

// File: rtl/coin_collector.sv
// Player/coin overlap detection, coin alive flags and BCD score.
// Once per frame the FSM walks the coins one per Clk and tests the player hitbox
// against each live coin; a hit kills the coin, bumps the score and pulses collect_pulse.
// Optional feature macro: COIN_RESPAWN_EN (dead coins return after RESPAWN_FRAMES frames).
// dbg_state exposes the scan FSM state for observation.
//
// Handshake: there is no valid/ready flow here. frame_clk is a level sampled in the Clk
// domain; its rising edge starts one scan. A rising edge seen while a scan is in progress
// is ignored, and level_restart is a single-cycle command that wins over everything except Reset.
module coin_collector
  import coin_pkg::*;
#(
  parameter int NUM_COINS      = 4,
  parameter int COIN_W         = COIN_W_DEFAULT,
  parameter int COIN_H         = COIN_H_DEFAULT,
  parameter int PLAYER_W       = PLAYER_W_DEFAULT,
  parameter int PLAYER_H       = PLAYER_H_DEFAULT,
  parameter int SCORE_DIGITS   = 4,
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic [9:0]                process,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  input  logic                      level_restart,
  input  logic [10*NUM_COINS-1:0]   coin_x_flat,
  input  logic [10*NUM_COINS-1:0]   coin_y_flat,
  output logic [NUM_COINS-1:0]      coin_alive,
  output logic                      collect_pulse,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic                      all_collected,
  output collect_state_t            dbg_state
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COINS - 1);

  collect_state_t        state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  frame_clk_q;
  logic                  frame_rise_q;
  logic [NUM_COINS-1:0]  coin_alive_q, coin_alive_d;
  logic                  collect_q, collect_d;
  logic                  all_collected_q, all_collected_d;
  logic [10:0]           pwx, py, cx, cy;
  logic                  overlap;
  logic                  hit;

  // Frame tick edge detect; the rise flag is registered so the scan starts one Clk later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q  <= 1'b0;
      frame_rise_q <= 1'b0;
    end else begin
      frame_clk_q  <= frame_clk;
      frame_rise_q <= frame_clk & ~frame_clk_q;
    end
  end

  // Overlap test for the coin selected by idx_q, all in 11-bit unsigned world coordinates.
  always_comb begin
    pwx     = {1'b0, player_x} + {1'b0, process};
    py      = {1'b0, player_y};
    cx      = {1'b0, coin_x_flat[10*idx_q +: 10]};
    cy      = {1'b0, coin_y_flat[10*idx_q +: 10]};
    overlap = (pwx < cx + 11'(COIN_W))   && (cx < pwx + 11'(PLAYER_W)) &&
              (py  < cy + 11'(COIN_H))   && (cy < py  + 11'(PLAYER_H));
    hit     = (state_q == SCAN) && coin_alive_q[idx_q] && overlap && !level_restart;
  end

  // Scan FSM next state: one coin per Clk, then a DONE cycle before returning to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (frame_rise_q) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (level_restart) state_d = IDLE;
  end

  // Scan FSM registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef COIN_RESPAWN_EN
  localparam int RW = $clog2(RESPAWN_FRAMES + 1);
  logic [RW-1:0] resp_cnt_q [NUM_COINS];
  logic [RW-1:0] resp_cnt_d [NUM_COINS];

  // Alive flags with respawn: dead coins count frame ticks and come back at RESPAWN_FRAMES.
  always_comb begin
    coin_alive_d    = coin_alive_q;
    collect_d       = 1'b0;
    all_collected_d = all_collected_q;
    for (int i = 0; i < NUM_COINS; i++) begin
      resp_cnt_d[i] = resp_cnt_q[i];
      if (!coin_alive_q[i] && frame_rise_q) begin
        if (resp_cnt_q[i] == RW'(RESPAWN_FRAMES - 1)) begin
          coin_alive_d[i] = 1'b1;
          resp_cnt_d[i]   = '0;
        end else begin
          resp_cnt_d[i] = resp_cnt_q[i] + 1'b1;
        end
      end
    end
    if (hit) begin
      coin_alive_d[idx_q] = 1'b0;
      resp_cnt_d[idx_q]   = '0;
      collect_d           = 1'b1;
    end
    if (state_q == DONE) all_collected_d = (coin_alive_q == '0);
    if (level_restart) begin
      coin_alive_d    = '1;
      collect_d       = 1'b0;
      all_collected_d = 1'b0;
      for (int i = 0; i < NUM_COINS; i++) resp_cnt_d[i] = '0;
    end
  end

  // Respawn counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_COINS; i++) resp_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_COINS; i++) resp_cnt_q[i] <= resp_cnt_d[i];
    end
  end
`else
  // RESPAWN_FRAMES only has meaning when coins can respawn.
  logic unused_respawn_frames;
  assign unused_respawn_frames = ^RESPAWN_FRAMES;

  // Alive flags: a collected coin stays dead until level_restart or Reset.
  always_comb begin
    coin_alive_d    = coin_alive_q;
    collect_d       = 1'b0;
    all_collected_d = all_collected_q;
    if (hit) begin
      coin_alive_d[idx_q] = 1'b0;
      collect_d           = 1'b1;
    end
    if (state_q == DONE) all_collected_d = (coin_alive_q == '0);
    if (level_restart) begin
      coin_alive_d    = '1;
      collect_d       = 1'b0;
      all_collected_d = 1'b0;
    end
  end
`endif

  // Alive flags, pickup pulse and all-collected flag registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      coin_alive_q    <= '1;
      collect_q       <= 1'b0;
      all_collected_q <= 1'b0;
    end else begin
      coin_alive_q    <= coin_alive_d;
      collect_q       <= collect_d;
      all_collected_q <= all_collected_d;
    end
  end

  coin_score_bcd #(
    .SCORE_DIGITS(SCORE_DIGITS)
  ) u_score (
    .Clk    (Clk),
    .clr_i  (Reset),
    .inc_i  (hit),
    .score_o(score_bcd)
  );

  assign coin_alive    = coin_alive_q;
  assign collect_pulse = collect_q;
  assign all_collected = all_collected_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_coin_collector.sv
// Bench for coin_collector: directed scenarios plus randomized frames, checked
// against a frame-level model (integer score, per-coin alive bits, rectangle overlap).
`timescale 1ns/1ps
module tb_coin_collector;
  import coin_pkg::*;

  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int RF    = 3;
  localparam int EXP_W = N + 1 + 4*SD;

  logic              Clk;
  logic              Reset;
  logic              frame_clk;
  logic [9:0]        process;
  logic [9:0]        player_x;
  logic [9:0]        player_y;
  logic              level_restart;
  logic [10*N-1:0]   coin_x_flat;
  logic [10*N-1:0]   coin_y_flat;
  logic [N-1:0]      coin_alive;
  logic              collect_pulse;
  logic [4*SD-1:0]   score_bcd;
  logic              all_collected;
  collect_state_t    dbg_state;

  coin_collector #(
    .NUM_COINS(N), .SCORE_DIGITS(SD), .RESPAWN_FRAMES(RF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .process(process),
    .player_x(player_x), .player_y(player_y), .level_restart(level_restart),
    .coin_x_flat(coin_x_flat), .coin_y_flat(coin_y_flat),
    .coin_alive(coin_alive), .collect_pulse(collect_pulse), .score_bcd(score_bcd),
    .all_collected(all_collected), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model state
  int  checks   = 0;
  int  failures = 0;
  bit  m_alive [N];
  int  m_score;
  int  m_dead  [N];
  int  cx [N];
  int  cy [N];
  logic [EXP_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [4*SD-1:0] to_bcd(input int s);
    logic [4*SD-1:0] r;
    int v;
    r = '0;
    v = s;
    for (int k = 0; k < SD; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [N-1:0] alive_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_alive[i];
    return v;
  endfunction

  function automatic bit overlaps(input int i);
    int pwx, py;
    pwx = int'(player_x) + int'(process);
    py  = int'(player_y);
    return (pwx < cx[i] + 16) && (cx[i] < pwx + 16) && (py < cy[i] + 28) && (cy[i] < py + 32);
  endfunction

  // Driver tasks
  task automatic drive_coins();
    for (int i = 0; i < N; i++) begin
      coin_x_flat[10*i +: 10] = 10'(cx[i]);
      coin_y_flat[10*i +: 10] = 10'(cy[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_alive[i] = 1'b1;
      m_dead[i]  = 0;
    end
    m_score = 0;
  endtask

  task automatic set_all_far();
    for (int i = 0; i < N; i++) begin
      cx[i] = 900;
      cy[i] = 10;
    end
  endtask

  task automatic set_player(input int proc, input int px, input int py);
    process  = 10'(proc);
    player_x = 10'(px);
    player_y = 10'(py);
  endtask

  task automatic place_on_player(input int i);
    cx[i] = int'(player_x) + int'(process);
    cy[i] = int'(player_y);
  endtask

  task automatic restart();
    level_restart = 1'b1;
    step();
    level_restart = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_alive[i] = 1'b1;
      m_dead[i]  = 0;
    end
    check_eq("restart_alive", 32'(coin_alive), 32'(alive_vec()));
    check_eq("restart_pulse", 32'(collect_pulse), 32'd0);
    check_eq("restart_score", 32'(score_bcd), 32'(to_bcd(m_score)));
    check_eq("restart_allc",  32'(all_collected), 32'd0);
  endtask

  // One full frame: model the serialised scan, then step the DUT and compare each coin result.
  task automatic run_frame();
    logic [EXP_W-1:0] e;
    bit h;
    drive_coins();
`ifdef COIN_RESPAWN_EN
    for (int i = 0; i < N; i++) begin
      if (!m_alive[i]) begin
        m_dead[i]++;
        if (m_dead[i] == RF) begin
          m_alive[i] = 1'b1;
          m_dead[i]  = 0;
        end
      end
    end
`endif
    for (int i = 0; i < N; i++) begin
      h = m_alive[i] && overlaps(i);
      if (h) begin
        m_alive[i] = 1'b0;
        m_dead[i]  = 0;
        if (m_score < 9999) m_score++;
      end
      exp_q.push_back({alive_vec(), h, to_bcd(m_score)});
    end
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    check_eq("pre_pulse0", 32'(collect_pulse), 32'd0);
    step();
    check_eq("pre_pulse1", 32'(collect_pulse), 32'd0);
    for (int i = 0; i < N; i++) begin
      step();
      e = exp_q.pop_front();
      check_eq("coin_alive", 32'(coin_alive),    32'(e[EXP_W-1 -: N]));
      check_eq("coin_pulse", 32'(collect_pulse), 32'(e[4*SD]));
      check_eq("coin_score", 32'(score_bcd),     32'(e[4*SD-1:0]));
    end
    step();
    check_eq("post_pulse", 32'(collect_pulse), 32'd0);
    check_eq("all_coll",   32'(all_collected), 32'(alive_vec() == '0));
    step();
    step();
  endtask

  // Stimulus and final report
  initial begin
    Reset = 1'b1; frame_clk = 1'b0; level_restart = 1'b0;
    process = '0; player_x = '0; player_y = '0;
    coin_x_flat = '0; coin_y_flat = '0;
    model_reset();
    step(); step();
    Reset = 1'b0;
    check_eq("rst_alive", 32'(coin_alive), 32'hF);
    check_eq("rst_score", 32'(score_bcd), 32'd0);
    check_eq("rst_pulse", 32'(collect_pulse), 32'd0);
    check_eq("rst_allc",  32'(all_collected), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));

    // T1: three frames without any overlap
    set_player(0, 300, 300);
    set_all_far();
    for (int f = 0; f < 3; f++) run_frame();
    check_eq("t1_alive", 32'(coin_alive), 32'hF);
    check_eq("t1_score", 32'(score_bcd), 32'd0);

    // T2: scrolled world, coin1 under the player
    set_player(100, 300, 300);
    set_all_far();
    cx[1] = 400; cy[1] = 300;
    run_frame();
    check_eq("t2_alive", 32'(coin_alive), 32'hD);
    check_eq("t2_score", 32'(score_bcd), 32'h0001);

    // T3: coins 0 and 2 in the same frame
    restart();
    set_all_far();
    place_on_player(0);
    place_on_player(2);
    run_frame();
    check_eq("t3_alive", 32'(coin_alive), 32'hA);
    check_eq("t3_score", 32'(score_bcd), 32'h0003);

    // T4: touching edge is not a hit, one pixel of overlap is
    restart();
    set_all_far();
    cx[0] = 200; cy[0] = 300;
    set_player(0, 216, 300);
    run_frame();
    check_eq("t4_touch", 32'(coin_alive), 32'hF);
    set_player(0, 215, 300);
    run_frame();
    check_eq("t4_hit", 32'(coin_alive), 32'hE);

    // T5: fill the score to 9999, then hit once more at saturation
    while (m_score < 9999) begin
      restart();
      set_player(50, 200, 200);
      for (int i = 0; i < N; i++) place_on_player(i);
      run_frame();
    end
    check_eq("t5_full", 32'(score_bcd), 32'h9999);
    restart();
    set_all_far();
    place_on_player(3);
    run_frame();
    check_eq("t5_sat", 32'(score_bcd), 32'h9999);
    restart();
    check_eq("t5_rs_alive", 32'(coin_alive), 32'hF);
    check_eq("t5_rs_score", 32'(score_bcd), 32'h9999);

    // Reset in the middle of a scan
    for (int i = 0; i < N; i++) place_on_player(i);
    drive_coins();
    frame_clk = 1'b1; step(); frame_clk = 1'b0; step(); step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    model_reset();
    check_eq("mrst_alive", 32'(coin_alive), 32'hF);
    check_eq("mrst_score", 32'(score_bcd), 32'd0);
    check_eq("mrst_pulse", 32'(collect_pulse), 32'd0);
    check_eq("mrst_state", 32'(dbg_state), 32'(IDLE));
    step(); step();

    // level_restart in the middle of a scan discards the pending hit
    frame_clk = 1'b1; step(); frame_clk = 1'b0; step(); step();
    check_eq("mrs_coin0", 32'(coin_alive), 32'hE);
    check_eq("mrs_pulse", 32'(collect_pulse), 32'd1);
    check_eq("mrs_score", 32'(score_bcd), 32'h0001);
    level_restart = 1'b1;
    step();
    level_restart = 1'b0;
    m_score = 1;
    for (int i = 0; i < N; i++) begin m_alive[i] = 1'b1; m_dead[i] = 0; end
    check_eq("mrs_alive", 32'(coin_alive), 32'hF);
    check_eq("mrs_nopulse", 32'(collect_pulse), 32'd0);
    check_eq("mrs_hold", 32'(score_bcd), 32'h0001);
    check_eq("mrs_state", 32'(dbg_state), 32'(IDLE));
    step();
    check_eq("mrs_quiet", 32'(collect_pulse), 32'd0);
    check_eq("mrs_quiet_score", 32'(score_bcd), 32'h0001);

    // T6: respawn behaviour of a collected coin
    set_player(0, 300, 300);
    set_all_far();
    place_on_player(0);
    run_frame();
    check_eq("t6_dead", 32'(coin_alive[0]), 32'd0);
    set_all_far();
`ifdef COIN_RESPAWN_EN
    run_frame();
    run_frame();
    check_eq("t6_still_dead", 32'(coin_alive[0]), 32'd0);
    run_frame();
    check_eq("t6_back", 32'(coin_alive[0]), 32'd1);
`else
    for (int f = 0; f < 10; f++) run_frame();
    check_eq("t6_stays_dead", 32'(coin_alive[0]), 32'd0);
`endif

    // Randomized frames with coins scattered around the player
    for (int f = 0; f < 60; f++) begin
      int pwx;
      if ($urandom_range(0, 3) == 0) restart();
      set_player(int'($urandom_range(0, 400)), int'($urandom_range(20, 560)),
                 int'($urandom_range(40, 400)));
      pwx = int'(player_x) + int'(process);
      for (int i = 0; i < N; i++) begin
        cx[i] = pwx - 24 + int'($urandom_range(0, 48));
        if (cx[i] < 0) cx[i] = 0;
        cy[i] = int'(player_y) - 36 + int'($urandom_range(0, 72));
      end
      run_frame();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
